// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard and its writeback reservation shifter.
// No logic, no latency; pure declarations.
// Unit codes at or above FU_NONE never reserve the writeback port.
package issue_scoreboard_pkg;

    localparam logic [1:0] FU_X    = 2'd0;
    localparam logic [1:0] FU_M    = 2'd1;
    localparam logic [1:0] FU_NONE = 2'd2;

    localparam int XLAT_DEF = 4;
    localparam int MLAT_DEF = 6;
    localparam int LAT_W    = 4;

    typedef struct packed {
        logic       valid;
        logic [4:0] regdest;
    } slot_t;

    function automatic logic fu_has_unit(input logic [1:0] fu);
        return fu < FU_NONE;
    endfunction

endpackage

// File: rtl/wb_reservation_shifter.sv
// Writeback-port reservation ring: slot[k] valid means a writeback happens k cycles from now.
// Latency: insert lands in slot[L-1] at the next edge; head and occupancy query are registered/combinational reads.
// Backpressure: none; the caller must not insert into an occupied position (checked via query_busy).
module wb_reservation_shifter
    import issue_scoreboard_pkg::*;
#(
    parameter int MLAT = MLAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ins_vld,
    input  logic [LAT_W-1:0] ins_lat,
    input  logic [4:0]       ins_regdest,
    input  logic [LAT_W-1:0] query_lat,
    output slot_t            head,
    output logic             query_busy
);

    slot_t slot_q [MLAT];
    slot_t slot_d [MLAT];

    always_comb begin
        for (int k = 0; k < MLAT; k++) begin
            slot_d[k] = '0;
        end
        for (int k = 0; k < MLAT - 1; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        // A new reservation overrides whatever would have shifted into its position.
        for (int k = 0; k < MLAT; k++) begin
            if (ins_vld && (ins_lat == LAT_W'(k + 1))) begin
                slot_d[k] = '{valid: 1'b1, regdest: ins_regdest};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MLAT; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MLAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // A query at L == MLAT matches no slot and therefore never reports busy.
    always_comb begin
        query_busy = 1'b0;
        for (int k = 0; k < MLAT; k++) begin
            if (query_lat == LAT_W'(k)) begin
                query_busy = slot_q[k].valid;
            end
        end
    end

    assign head = slot_q[0];

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: RAW/WAW hazards on in-flight registers plus single writeback-port reservation.
// Latency: is_stall/is_fire combinational; wb_* and pending registered. SCOREBOARD_BYPASS_EN lets readers issue in the writeback cycle.
// Backpressure: is_stall holds the instruction at issue; an accepted instruction can never be refused later.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int XLAT = XLAT_DEF,
    parameter int MLAT = MLAT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_valid,
    input  logic [1:0]  is_functionalunit,
    input  logic [4:0]  is_rs,
    input  logic        is_users,
    input  logic [4:0]  is_rt,
    input  logic        is_usert,
    input  logic [4:0]  is_regdest,
    input  logic        is_writereg,
    output logic        is_stall,
    output logic        is_fire,
    output logic        wb_valid,
    output logic [4:0]  wb_regdest,
    output logic [31:0] pending
);

    logic             has_unit;
    logic [LAT_W-1:0] lat;
    logic             wr;
    logic             raw_hzd;
    logic             waw_hzd;
    logic             port_busy;
    logic             slot_busy;
    slot_t            head;
    logic [31:0]      pend_q;
    logic [31:0]      pend_d;
    logic [31:0]      pend_haz;

    assign has_unit = fu_has_unit(is_functionalunit);
    assign lat      = (is_functionalunit == FU_X) ? LAT_W'(XLAT) : LAT_W'(MLAT);
    assign wr       = is_writereg & (is_regdest != 5'd0) & has_unit;

`ifdef SCOREBOARD_BYPASS_EN
    // The register leaving through the writeback port this cycle is visible via write-through.
    always_comb begin
        pend_haz = pend_q;
        if (head.valid) begin
            pend_haz[head.regdest] = 1'b0;
        end
    end
`else
    assign pend_haz = pend_q;
`endif

    assign raw_hzd   = (is_users & pend_haz[is_rs]) | (is_usert & pend_haz[is_rt]);
    assign waw_hzd   = wr & pend_haz[is_regdest];
    assign port_busy = has_unit & slot_busy;

    assign is_stall = is_valid & (raw_hzd | waw_hzd | port_busy);
    assign is_fire  = is_valid & ~is_stall;

    wb_reservation_shifter #(
        .MLAT (MLAT)
    ) u_shifter (
        .clock       (clock),
        .reset       (reset),
        .ins_vld     (is_fire & has_unit),
        .ins_lat     (lat),
        .ins_regdest (wr ? is_regdest : 5'd0),
        .query_lat   (lat),
        .head        (head),
        .query_busy  (slot_busy)
    );

    // Clear first, then set, so a same-register set wins.
    always_comb begin
        pend_d = pend_q;
        if (head.valid) begin
            pend_d[head.regdest] = 1'b0;
        end
        if (is_fire && wr) begin
            pend_d[is_regdest] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign wb_valid   = head.valid;
    assign wb_regdest = head.valid ? head.regdest : 5'd0;
    assign pending    = pend_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic, checked against a list of
// in-flight writebacks (issue cycle + latency) kept by the bench.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int XL = XLAT_DEF;
    localparam int ML = MLAT_DEF;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        is_valid = 1'b0;
    logic [1:0]  is_functionalunit = 2'd0;
    logic [4:0]  is_rs = 5'd0;
    logic        is_users = 1'b0;
    logic [4:0]  is_rt = 5'd0;
    logic        is_usert = 1'b0;
    logic [4:0]  is_regdest = 5'd0;
    logic        is_writereg = 1'b0;
    logic        is_stall;
    logic        is_fire;
    logic        wb_valid;
    logic [4:0]  wb_regdest;
    logic [31:0] pending;

    issue_scoreboard #(.XLAT(XL), .MLAT(ML)) dut (
        .clock             (clock),
        .reset             (reset),
        .is_valid          (is_valid),
        .is_functionalunit (is_functionalunit),
        .is_rs             (is_rs),
        .is_users          (is_users),
        .is_rt             (is_rt),
        .is_usert          (is_usert),
        .is_regdest        (is_regdest),
        .is_writereg       (is_writereg),
        .is_stall          (is_stall),
        .is_fire           (is_fire),
        .wb_valid          (wb_valid),
        .wb_regdest        (wb_regdest),
        .pending           (pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         wbc;
        logic [4:0] rd;
    } res_t;

    typedef struct {
        logic        stall;
        logic        fire;
        logic        wbv;
        logic [4:0]  wbr;
        logic [31:0] pend;
    } exp_t;

    res_t inflight[$];
    exp_t exp_q[$];
    int   now = 0;
    int   checks = 0;
    int   errors = 0;

    // Register r is in flight from the cycle after issue up to and including its writeback cycle.
    function automatic bit m_pend(int r, bit haz);
        if (r == 0) return 1'b0;
        foreach (inflight[i]) begin
            if (inflight[i].rd == 5'(r) && inflight[i].wbc >= now &&
                !(haz && BYP && inflight[i].wbc == now))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_port_taken(int c);
        foreach (inflight[i]) if (inflight[i].wbc == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("is_stall",   32'(is_stall),   32'(e.stall));
            check("is_fire",    32'(is_fire),    32'(e.fire));
            check("wb_valid",   32'(wb_valid),   32'(e.wbv));
            check("wb_regdest", 32'(wb_regdest), 32'(e.wbr));
            check("pending",    pending,         e.pend);
        end
    end

    task automatic step(input bit rst, input logic v, input logic [1:0] fu,
                        input logic [4:0] rs, input logic us, input logic [4:0] rt, input logic ut,
                        input logic [4:0] rd, input logic wrg, output bit fired);
        res_t keep[$];
        exp_t e;
        bit   has_unit, wr, raw, waw, port;
        int   lat;
        @(posedge clock);
        #1;
        reset = rst;
        is_valid = v; is_functionalunit = fu; is_rs = rs; is_users = us;
        is_rt = rt; is_usert = ut; is_regdest = rd; is_writereg = wrg;
        if (rst) inflight.delete();
        foreach (inflight[i]) if (inflight[i].wbc >= now) keep.push_back(inflight[i]);
        inflight = keep;
        has_unit = (fu < 2'd2);
        lat      = (fu == 2'd0) ? XL : ML;
        wr       = wrg && (rd != 5'd0) && has_unit;
        raw      = (us && m_pend(int'(rs), 1'b1)) || (ut && m_pend(int'(rt), 1'b1));
        waw      = wr && m_pend(int'(rd), 1'b1);
        port     = has_unit && m_port_taken(now + lat);
        e.stall  = v && (raw || waw || port);
        e.fire   = v && !e.stall;
        e.wbv    = 1'b0;
        e.wbr    = 5'd0;
        foreach (inflight[i]) if (inflight[i].wbc == now) begin e.wbv = 1'b1; e.wbr = inflight[i].rd; end
        for (int r = 0; r < 32; r++) e.pend[r] = m_pend(r, 1'b0);
        exp_q.push_back(e);
        if (!rst && e.fire && has_unit) inflight.push_back('{wbc: now + lat, rd: wr ? rd : 5'd0});
        now++;
        #1;
        fired = is_fire;
    endtask

    task automatic idle(input int n);
        bit f;
        repeat (n) step(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, f);
    endtask

    task automatic issue(input logic [1:0] fu, input logic [4:0] rs, input logic us,
                         input logic [4:0] rt, input logic ut, input logic [4:0] rd,
                         input logic wrg, output int stalls);
        bit f;
        stalls = 0;
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 1'b1, fu, rs, us, rt, ut, rd, wrg, f);
            if (f) return;
            stalls++;
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: instruction still stalled after %0d cycles, required to fire", stalls);
    endtask

    initial begin : stim
        int  s;
        bit  f;
        bit  have;
        logic       cv, cus, cut, cwr;
        logic [1:0] cfu;
        logic [4:0] crs, crt, crd;

        repeat (3) step(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, f);

        // Basic X write then RAW reader of r5.
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, s);
        check("first_fire_stalls", 32'(s), 32'd0);
        issue(FU_NONE, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s);
        check("raw_stalls", 32'(s), BYP ? 32'd3 : 32'd4);
        idle(8);

        // Port conflict: M r7 then X r8 two cycles later.
        issue(FU_M, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, s);
        idle(1);
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, s);
        check("port_stalls", 32'(s), 32'd1);
        idle(8);

        // WAW on r9, then register 0 is never tracked.
        issue(FU_M, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, s);
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, s);
        check("waw_stalls", 32'(s), BYP ? 32'd5 : 32'd6);
        idle(8);
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, s);
        issue(FU_NONE, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, s);
        check("r0_reader_stalls", 32'(s), 32'd0);
        idle(6);

        // Reset while three reservations are in flight.
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, s);
        issue(FU_M, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, s);
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, s);
        step(1'b0, 1'b1, FU_NONE, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, f);
        check("reader_blocked", 32'(f), 32'd0);
        step(1'b1, 1'b1, FU_NONE, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, f);
        step(1'b0, 1'b1, FU_NONE, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, f);
        check("reader_after_reset", 32'(f), 32'd1);
        idle(4);

        // Unit 2 never touches the port; unit 0 without a write still reserves it.
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, s);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2'd2 + 2'(i % 2), 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, f);
            check("no_unit_fire", 32'(f), 32'd1);
        end
        issue(FU_X, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b0, s);
        check("nowrite_stalls", 32'(s), 32'd0);
        idle(6);

        // Random traffic; a stalled instruction is held until it fires.
        have = 1'b0;
        cv = 0; cfu = 0; crs = 0; cus = 0; crt = 0; cut = 0; crd = 0; cwr = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!have) begin
                cv  = ($urandom_range(0, 9) != 0);
                cfu = 2'($urandom_range(0, 3));
                crs = 5'($urandom_range(0, 7));
                crt = 5'($urandom_range(0, 7));
                crd = 5'($urandom_range(0, 7));
                cus = 1'($urandom_range(0, 1));
                cut = 1'($urandom_range(0, 1));
                cwr = 1'($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 99) == 0) begin
                step(1'b1, cv, cfu, crs, cus, crt, cut, crd, cwr, f);
                have = 1'b0;
            end else begin
                step(1'b0, cv, cfu, crs, cus, crt, cut, crd, cwr, f);
                have = cv && !f;
            end
        end
        idle(ML + 2);

        repeat (2) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue-stage controller that decides each cycle whether the instruction at issue may enter its functional unit.
- Units: X (integer ALU/shifter pipe, fixed latency XLAT) and M (memory pipe, fixed latency MLAT).
- Detects RAW and WAW hazards against in-flight destinations, and reserves the single register-file writeback port.
- Sits between decode/issue and the Execute_X / memory units; drives the issue stall.

Parameters:
- XLAT, 4: cycles from the issue cycle to the X writeback cycle (legal range 1..MLAT).
- MLAT, 6: cycles from the issue cycle to the M writeback cycle (legal range XLAT..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- is_valid  in  1  an instruction is present at issue.
- is_functionalunit  in  2  0 = X, 1 = M, 2 or 3 = no unit (no writeback, no reservation).
- is_rs  in  5  source A register.
- is_users  in  1  instruction reads rs.
- is_rt  in  5  source B register.
- is_usert  in  1  instruction reads rt.
- is_regdest  in  5  destination register.
- is_writereg  in  1  instruction writes regdest.
- is_stall  out  1  hold the instruction at issue this cycle (combinational).
- is_fire  out  1  the instruction is accepted this cycle (combinational); equals is_valid & ~is_stall.
- wb_valid  out  1  a reserved writeback occurs this cycle (registered slot 0).
- wb_regdest  out  5  destination of that writeback; 0 when wb_valid = 0.
- pending  out  32  per-register in-flight mask; bit 0 is always 0.

Behaviour:
- State:
  - Reservation shift register, slot[0..MLAT-1], each holding {valid, regdest}. slot[k] valid means the writeback happens k cycles from now.
  - pend[31:0], one in-flight bit per register.
- Reset (asynchronous, active-high): all slots invalid with regdest 0, pend = 0, wb_valid = 0, wb_regdest = 0. Reset asserted mid-operation discards every reservation immediately; is_stall then depends only on the current inputs.
- Latency L: XLAT for unit 0, MLAT for unit 1. Unit codes 2/3 have no L and never conflict on the port.
- Effective write: wr = is_writereg & (is_regdest != 0) & (unit is 0 or 1). A write to register 0 is never tracked.
- Hazard terms, evaluated in the current cycle:
  - RAW: (is_users & pend[is_rs]) | (is_usert & pend[is_rt]).
  - WAW: wr & pend[is_regdest].
  - Port conflict: unit is 0 or 1, L < MLAT, and slot[L].valid. slot[L] shifts into slot[L-1] at the next edge.
- is_stall = is_valid & (RAW | WAW | port conflict). is_stall = 0 when is_valid = 0.
- Each rising edge:
  - slot[k] <= slot[k+1] for k = 0..MLAT-2.
  - slot[MLAT-1] <= invalid.
  - If is_fire and the unit is 0 or 1, slot[L-1] <= {1, wr ? is_regdest : 0}, overriding the shift value. The slot is valid even when wr = 0 (port reserved, no register write); wb_valid still asserts L cycles later with wb_regdest = 0.
  - pend update, in this order:
    - Clear: if slot[0].valid, clear pend[slot[0].regdest].
    - Set: if is_fire & wr, set pend[is_regdest].
  - Set wins over clear only when both name the same register. This cannot occur without the bypass feature (WAW stalls it), but it is legal with SCOREBOARD_BYPASS_EN.
- Timing: an instruction that fires in cycle c has wb_valid = 1 in cycle c + L, and its pend bit reads 0 from cycle c + L + 1.
- At most one fire per cycle; no internal throughput limit beyond the hazards above.

Optional Feature:
- SCOREBOARD_BYPASS_EN defined:
  - A register whose writeback is in slot[0] this cycle is treated as not pending in the RAW and WAW terms. This is the pend mask with bit slot[0].regdest masked off when slot[0].valid.
  - The dependent instruction issues in the writeback cycle, relying on the register-file write-through.
- Undefined: RAW and WAW use raw pend, so a dependent instruction issues one cycle after the writeback cycle.

Decomposition:
- Shared package:
  - Functional-unit codes (FU_X = 0, FU_M = 1, FU_NONE = 2).
  - Default latency constants XLAT_DEF = 4, MLAT_DEF = 6.
  - Slot record typedef {valid, regdest[4:0]}.
- One natural sub-module: wb_reservation_shifter, the slot array with shift, insert at L-1 and the slot[L] occupancy query. Hazard logic and pend stay in the top level.

Test Plan:
- Reset, then issue X with rd = 5, wr = 1 at cycle 0 -> is_fire = 1; pend[5] = 1 in cycles 1..4; wb_valid = 1 with wb_regdest = 5 in cycle 4; pend[5] = 0 from cycle 5.
- RAW: X writes r5 at cycle 0, next instruction reads rs = 5 from cycle 1 -> is_stall = 1 in cycles 1..4 and fire in cycle 5; with SCOREBOARD_BYPASS_EN, stall in cycles 1..3 and fire in cycle 4.
- Port conflict: M writes r7 at cycle 0 (writeback cycle 6); X writes r8 at cycle 2 -> X stalls in cycle 2 (slot[4] valid), fires in cycle 3, and wb_regdest sequence is 7 at cycle 6, 8 at cycle 7.
- WAW plus register 0: M writes r9, then X writes r9 -> stall until cycle 7; an X write to r0 never sets pend and never stalls a reader of r0.
- Reset pulse while three reservations are in flight -> wb_valid, wb_regdest and pend are 0 immediately; a previously blocked reader of r5 fires in the first cycle after reset deasserts.
- Unit 2 instruction, and unit 0 with writereg = 0 -> unit 2 never stalls on the port and reserves nothing; unit 0 with writereg = 0 reserves the port (wb_valid = 1, wb_regdest = 0 at cycle +4) without setting pend.
